// File: rtl/uart_clk_pkg.sv
// rtl/uart_clk_pkg.sv - shared types and constants for the fabric baud tick generator
package uart_clk_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int PHASE_W                = 4;
    localparam int DEFAULT_STARTUP_CYCLES = 1024;

endpackage

// File: rtl/baud_frac_div.sv
// rtl/baud_frac_div.sv - fractional down-counter: count, fraction accumulator and carry reload
module baud_frac_div #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [DIV_W-1:0]  load_val,
    input  logic [FRAC_W-1:0] load_frac,
    input  logic [DIV_W-1:0]  reload_val,
    input  logic [FRAC_W-1:0] reload_frac,
    output logic              wrap
);

    logic [DIV_W:0]  count_q;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0] acc_sum;
    logic [DIV_W:0]  reload_cnt;

    assign wrap    = en && (count_q == '0);
    assign acc_sum = {1'b0, acc_q} + {1'b0, reload_frac};
    // One extra bit so an all-ones divisor plus carry stretches the period instead of wrapping.
    assign reload_cnt = {1'b0, reload_val} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            acc_q   <= '0;
        end else if (load) begin
            count_q <= {1'b0, load_val};
            acc_q   <= load_frac;
        end else if (wrap) begin
            count_q <= reload_cnt;
            acc_q   <= acc_sum[FRAC_W-1:0];
        end else if (en) begin
            count_q <= count_q - (DIV_W+1)'(1);
        end
    end

endmodule

// File: rtl/fabric_baud_tick_gen.sv
// rtl/fabric_baud_tick_gen.sv - startup wait, config handshake with shadow, and x16/x1 baud strobes
module fabric_baud_tick_gen
    import uart_clk_pkg::*;
#(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 3,
    parameter int STARTUP_CYCLES = DEFAULT_STARTUP_CYCLES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [DIV_W-1:0]  BAUD_VAL,
    input  logic [FRAC_W-1:0] BAUD_FRAC,
    output logic              LOCKED,
    output logic              TICK_X16,
    output logic              TICK_X1
);

    localparam int SC_W = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SC_W-1:0] STARTUP_LAST = SC_W'(STARTUP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [SC_W-1:0]     startup_q;
    logic                locked_q;
    logic [DIV_W-1:0]    active_val_q, shadow_val_q, sel_val;
    logic [FRAC_W-1:0]   active_frac_q, shadow_frac_q, sel_frac;
    logic                pending_q;
    logic [PHASE_W-1:0]  phase_q;
    logic                tick_x16_q, tick_x1_q;
    logic                div_load, div_en, wrap, shadow_fire;

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        case (state_q)
            ST_WAIT: if (startup_q == STARTUP_LAST) state_d = ST_IDLE;
            ST_IDLE: begin
                if (CFG_VALID) begin
                    state_d  = ST_RUN;
                    div_load = 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_WAIT;
        else          state_q <= state_d;
    end

    assign CFG_READY   = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pending_q);
    assign shadow_fire = CFG_VALID && CFG_READY && (state_q == ST_RUN);
    assign div_en      = (state_q == ST_RUN) && EN;
    // A pending shadow takes effect on the reload itself, not one period later.
    assign sel_val     = pending_q ? shadow_val_q  : active_val_q;
    assign sel_frac    = pending_q ? shadow_frac_q : active_frac_q;

    baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .load        (div_load),
        .en          (div_en),
        .load_val    (BAUD_VAL),
        .load_frac   (BAUD_FRAC),
        .reload_val  (sel_val),
        .reload_frac (sel_frac),
        .wrap        (wrap)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            startup_q     <= '0;
            locked_q      <= 1'b0;
            active_val_q  <= '0;
            active_frac_q <= '0;
            shadow_val_q  <= '0;
            shadow_frac_q <= '0;
            pending_q     <= 1'b0;
            phase_q       <= '0;
            tick_x16_q    <= 1'b0;
            tick_x1_q     <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) startup_q <= startup_q + SC_W'(1);
            if ((state_q == ST_WAIT) && (state_d == ST_IDLE)) locked_q <= 1'b1;
            if (div_load) begin
                active_val_q  <= BAUD_VAL;
                active_frac_q <= BAUD_FRAC;
                phase_q       <= '0;
            end
            if (wrap) begin
                phase_q <= phase_q + PHASE_W'(1);
                if (pending_q) begin
                    active_val_q  <= shadow_val_q;
                    active_frac_q <= shadow_frac_q;
                    pending_q     <= 1'b0;
                end
            end
            // shadow_fire requires no pending shadow, so it never collides with the clear above.
            if (shadow_fire) begin
                shadow_val_q  <= BAUD_VAL;
                shadow_frac_q <= BAUD_FRAC;
                pending_q     <= 1'b1;
            end
            tick_x16_q <= wrap;
            tick_x1_q  <= wrap && (phase_q == '1);
        end
    end

    assign LOCKED   = locked_q;
    assign TICK_X16 = tick_x16_q;
    assign TICK_X1  = tick_x1_q;

endmodule

// File: tb/tb_fabric_baud_tick_gen.sv
// tb/tb_fabric_baud_tick_gen.sv - self-checking bench with a tick-schedule reference model
module tb_fabric_baud_tick_gen;

    localparam int DIV_W    = 8;
    localparam int FRAC_W   = 3;
    localparam int STARTUP  = 8;
    localparam int FRAC_ONE = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [DIV_W-1:0]  baud_val = '0;
    logic [FRAC_W-1:0] baud_frac = '0;
    logic              cfg_ready, locked, tick_x16, tick_x1;

    always #5 clk = ~clk;

    fabric_baud_tick_gen #(
        .DIV_W          (DIV_W),
        .FRAC_W         (FRAC_W),
        .STARTUP_CYCLES (STARTUP)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .EN        (en),
        .CFG_VALID (cfg_valid),
        .CFG_READY (cfg_ready),
        .BAUD_VAL  (baud_val),
        .BAUD_FRAC (baud_frac),
        .LOCKED    (locked),
        .TICK_X16  (tick_x16),
        .TICK_X1   (tick_x1)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tq[$];
    int t1q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: counts enabled edges until the next tick, fractions kept in eighths.
    localparam int M_WAIT = 0, M_IDLE = 1, M_RUN = 2;
    int m_state = M_WAIT;
    int wait_n = 0, left = 0, frac_sum = 0, nticks = 0;
    int a_val = 0, a_frac = 0, s_val = 0, s_frac = 0;
    bit pend = 0, take_shadow = 0;
    bit exp_ready = 0, exp_locked = 0, exp_x16 = 0, exp_x1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_WAIT; wait_n = 0; left = 0; frac_sum = 0; nticks = 0;
            a_val = 0; a_frac = 0; s_val = 0; s_frac = 0; pend = 0;
            exp_ready = 0; exp_locked = 0; exp_x16 = 0; exp_x1 = 0;
        end else begin
            exp_x16 = 0;
            exp_x1  = 0;
            case (m_state)
                M_WAIT: begin
                    wait_n++;
                    if (wait_n == STARTUP) begin
                        m_state    = M_IDLE;
                        exp_locked = 1;
                    end
                end
                M_IDLE: begin
                    if (cfg_valid) begin
                        a_val    = int'(baud_val);
                        a_frac   = int'(baud_frac);
                        frac_sum = a_frac;
                        left     = a_val + 1;
                        nticks   = 0;
                        m_state  = M_RUN;
                    end
                end
                default: begin
                    take_shadow = cfg_valid && !pend;
                    if (en) begin
                        left--;
                        if (left == 0) begin
                            exp_x16 = 1;
                            exp_x1  = (nticks % 16) == 15;
                            nticks++;
                            if (pend) begin
                                a_val  = s_val;
                                a_frac = s_frac;
                                pend   = 0;
                            end
                            frac_sum = frac_sum + a_frac;
                            left     = a_val + 1 + ((frac_sum >= FRAC_ONE) ? 1 : 0);
                            frac_sum = frac_sum % FRAC_ONE;
                        end
                    end
                    if (take_shadow) begin
                        s_val  = int'(baud_val);
                        s_frac = int'(baud_frac);
                        pend   = 1;
                    end
                end
            endcase
            exp_ready = (m_state == M_IDLE) || (m_state == M_RUN && !pend);
        end
    end

    always @(negedge clk) begin
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        check("locked",    32'(locked),    32'(exp_locked));
        check("tick_x16",  32'(tick_x16),  32'(exp_x16));
        check("tick_x1",   32'(tick_x1),   32'(exp_x1));
        if (tick_x16 === 1'b1) tq.push_back(cyc);
        if (tick_x1 === 1'b1)  t1q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic offer(input int v, input int f, output int acc_cyc);
        baud_val  = DIV_W'(v);
        baud_frac = FRAC_W'(f);
        cfg_valid = 1'b1;
        acc_cyc   = -1;
        for (int n = 0; n < 400; n++) begin
            if (cfg_ready === 1'b1) begin
                step();
                acc_cyc = cyc;
                break;
            end
            step();
        end
        cfg_valid = 1'b0;
        check("offer_accepted", 32'(acc_cyc >= 0), 32'(1));
    endtask

    task automatic wait_ticks(input int cnt, input int budget);
        int n;
        n = 0;
        while (tq.size() < cnt && n < budget) begin
            step();
            n++;
        end
        check("tick_wait", 32'(tq.size() >= cnt), 32'(1));
    endtask

    task automatic restart(output int rel);
        int n;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rel   = cyc;
        wait_locked(n);
        check("startup_edges", n, STARTUP);
    endtask

    initial begin
        int n, a, a2, a3, rel, base, prev;
        int gap26[16] = '{27, 27, 27, 27, 27, 27, 27, 28, 27, 27, 27, 27, 27, 27, 27, 28};
        bit drop;

        // Startup with a configuration already offered during reset and WAIT.
        en = 1'b1; cfg_valid = 1'b1; baud_val = 8'd26; baud_frac = 3'd1;
        repeat (3) step();
        rst_n = 1'b1;
        rel = cyc;
        wait_locked(n);
        check("startup_edges", n, STARTUP);
        tq.delete(); t1q.delete();
        offer(26, 1, a);
        check("accept_after_lock", a - rel, STARTUP + 1);
        wait_ticks(17, 600);
        prev = a;
        for (int i = 0; i < 16 && i < tq.size(); i++) begin
            check("gap_26_1", tq[i] - prev, gap26[i]);
            prev = tq[i];
        end
        check("x1_present", 32'(t1q.size() >= 1), 32'(1));
        if (t1q.size() >= 1 && tq.size() >= 16) check("x1_on_16th", t1q[0], tq[15]);

        // Divisor zero: tick every cycle, then asynchronous reset mid-run.
        restart(rel);
        tq.delete(); t1q.delete();
        offer(0, 0, a);
        wait_ticks(40, 100);
        check("x16_first_v0", tq[0] - a, 1);
        for (int i = 1; i < 40; i++) check("gap_v0", tq[i] - tq[i-1], 1);
        check("x1_v0_count", 32'(t1q.size() >= 2), 32'(1));
        if (t1q.size() >= 2) check("x1_v0_gap", t1q[1] - t1q[0], 16);
        #2;
        check("x16_high_before_rst", 32'(tick_x16), 32'(1));
        rst_n = 1'b0;
        #1;
        check("rst_x16", 32'(tick_x16), 32'(0));
        check("rst_x1", 32'(tick_x1), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        step();
        baud_val = 8'd9; baud_frac = 3'd0; cfg_valid = 1'b1;
        step();
        rst_n = 1'b1;
        rel = cyc;
        wait_locked(n);
        check("startup_after_rst", n, STARTUP);
        tq.delete(); t1q.delete();
        offer(9, 0, a);
        check("accept_after_rst", a - rel, STARTUP + 1);

        // Reconfiguration 9 -> 3 mid-period, second offer held off.
        wait_ticks(2, 100);
        check("first_tick_v9", tq[0] - a, 10);
        check("gap_v9", tq[1] - tq[0], 10);
        base = tq[1];
        step(); step();
        offer(3, 0, a2);
        check("shadow_accept", a2 - base, 3);
        check("ready_low_pending", 32'(cfg_ready), 32'(0));
        offer(5, 0, a3);
        check("second_offer_edge", a3 - base, 11);
        wait_ticks(5, 100);
        check("tick_old_period", tq[2] - base, 10);
        check("tick_new_period", tq[3] - tq[2], 4);
        check("tick_third_cfg", tq[4] - tq[3], 6);

        // EN low for 5 cycles mid-period defers that tick by 5.
        tq.delete();
        wait_ticks(1, 100);
        step(); step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        wait_ticks(3, 100);
        check("en_deferred", tq[1] - tq[0], 11);
        check("en_resumed", tq[2] - tq[1], 6);

        // All-ones divisor with carry stretches rather than wraps.
        restart(rel);
        tq.delete();
        offer(255, 7, a);
        wait_ticks(2, 600);
        check("wide_first", tq[0] - a, 256);
        check("wide_carry", tq[1] - tq[0], 257);

        // Randomized enables, reconfigurations and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            drop = 0;
            if (cfg_valid && cfg_ready) drop = 1;
            else if (!cfg_valid && $urandom_range(0, 29) == 0) begin
                cfg_valid = 1'b1;
                baud_val  = DIV_W'($urandom_range(0, 12));
                baud_frac = FRAC_W'($urandom_range(0, 7));
            end
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
            step();
            if (drop) cfg_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
